// File: rtl/jk_pkg.sv
// Shared types for the JK bank initiator: FSM states, JK command codes
// and the baseline set/reset excitation function.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        APPLY = 2'd2,
        CHECK = 2'd3
    } state_t;

    // bit1 = j, bit0 = k
    typedef logic [1:0] jk_cmd_t;

    localparam jk_cmd_t JK_HOLD   = 2'b00;
    localparam jk_cmd_t JK_RESET  = 2'b01;
    localparam jk_cmd_t JK_SET    = 2'b10;
    localparam jk_cmd_t JK_TOGGLE = 2'b11;

    function automatic jk_cmd_t excite(input logic q, input logic t);
        jk_cmd_t cmd;
        cmd = JK_HOLD;
        unique case (1'b1)
            (!q && t): cmd = JK_SET;
            (q && !t): cmd = JK_RESET;
            default:   cmd = JK_HOLD;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/jk_seq_driver_excite.sv
// Per-bit JK excitation encoder.
// JK_TOGGLE_PREF_EN selects toggle drive for changing bits instead of set/reset.
module jk_excite
    import jk_pkg::*;
(
    input  logic q,
    input  logic t,
    output logic j,
    output logic k
);

    jk_cmd_t cmd;

`ifdef JK_TOGGLE_PREF_EN
    assign cmd = (q != t) ? JK_TOGGLE : JK_HOLD;
`else
    assign cmd = excite(q, t);
`endif

    assign j = cmd[1];
    assign k = cmd[0];

endmodule

// File: rtl/jk_seq_driver.sv
// Initiator for a bank of JK flip-flops: drives j/k toward a target,
// verifies q, retries. Build option JK_TOGGLE_PREF_EN (see jk_excite).
module jk_seq_driver
    import jk_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 1,
    parameter int ERRW      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done_valid,
    output logic             done_err,
    output logic [ERRW-1:0]  err_cnt
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] tgt_q;
    logic [RW-1:0]    retry_cnt;
    logic [WIDTH-1:0] drv_j;
    logic [WIDTH-1:0] drv_k;

    logic             accept;
    logic             match;
    logic             can_retry;

    logic             ready_d;
    logic             busy_d;
    logic [WIDTH-1:0] j_d;
    logic [WIDTH-1:0] k_d;
    logic             done_d;
    logic             derr_d;
    logic [ERRW-1:0]  errc_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_excite u_cell (
            .q (q_in[i]),
            .t (tgt_q[i]),
            .j (drv_j[i]),
            .k (drv_k[i])
        );
    end

    assign accept    = tgt_valid && tgt_ready;
    assign match     = (q_in == tgt_q);
    assign can_retry = (retry_cnt < RMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    state_nxt = APPLY;
            APPLY:   state_nxt = CHECK;
            CHECK: begin
                if (!match && can_retry) state_nxt = CALC;
                else                     state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they line up
    // with the state they describe.
    always_comb begin
        ready_d = (state_nxt == IDLE);
        busy_d  = (state_nxt != IDLE);
        j_d     = '0;
        k_d     = '0;
        done_d  = 1'b0;
        derr_d  = done_err;
        errc_d  = err_cnt;
        if (state == CALC) begin
            j_d = drv_j;
            k_d = drv_k;
        end
        if (state == CHECK && (match || !can_retry)) begin
            done_d = 1'b1;
            derr_d = !match;
            if (!match && err_cnt != '1) begin
                errc_d = err_cnt + ERRW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_ready  <= 1'b1;
            busy       <= 1'b0;
            j_out      <= '0;
            k_out      <= '0;
            done_valid <= 1'b0;
            done_err   <= 1'b0;
            err_cnt    <= '0;
        end else begin
            tgt_ready  <= ready_d;
            busy       <= busy_d;
            j_out      <= j_d;
            k_out      <= k_d;
            done_valid <= done_d;
            done_err   <= derr_d;
            err_cnt    <= errc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_q     <= '0;
            retry_cnt <= '0;
        end else if (accept) begin
            tgt_q     <= tgt_data;
            retry_cnt <= '0;
        end else if (state == CHECK && !match && can_retry) begin
            retry_cnt <= retry_cnt + RW'(1);
        end
    end

endmodule

// File: tb/tb_jk_seq_driver.sv
// Randomized bench for jk_seq_driver against a transaction-level model,
// with a behavioural JK bank (stuck-at-0 bits injectable) on q_in.
module tb_jk_seq_driver;

    localparam int W  = 4;
    localparam int MR = 1;
    localparam int EW = 3;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          tgt_valid = 1'b0;
    logic [W-1:0]  tgt_data  = '0;
    logic          tgt_ready;
    logic [W-1:0]  q_in;
    logic [W-1:0]  j_out;
    logic [W-1:0]  k_out;
    logic          busy;
    logic          done_valid;
    logic          done_err;
    logic [EW-1:0] err_cnt;

    logic [W-1:0]  q_reg = '0;
    logic [W-1:0]  stuck = '0;

    int vectors     = 0;
    int miscompares = 0;

    jk_seq_driver #(.WIDTH(W), .MAX_RETRY(MR), .ERRW(EW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tgt_valid  (tgt_valid),
        .tgt_ready  (tgt_ready),
        .tgt_data   (tgt_data),
        .q_in       (q_in),
        .j_out      (j_out),
        .k_out      (k_out),
        .busy       (busy),
        .done_valid (done_valid),
        .done_err   (done_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    // JK bank: stuck bits always read as 0
    assign q_in = q_reg & ~stuck;
    always @(posedge clk) q_reg <= (j_out & ~q_in) | (~k_out & q_in);

    typedef struct packed {
        logic          r;
        logic          b;
        logic          dv;
        logic          de;
        logic [W-1:0]  j;
        logic [W-1:0]  k;
        logic [EW-1:0] ec;
    } exp_t;

    exp_t exq[$];
    exp_t cur;

    function automatic exp_t mk(logic r, logic b, logic dv, logic de,
                                logic [W-1:0] j, logic [W-1:0] k,
                                logic [EW-1:0] ec);
        exp_t e;
        e.r = r; e.b = b; e.dv = dv; e.de = de;
        e.j = j; e.k = k; e.ec = ec;
        return e;
    endfunction

    // Per accepted request: queue one expectation per cycle until done.
    function automatic void plan(logic [W-1:0] t, logic [W-1:0] q0);
        logic [W-1:0]  q;
        logic [W-1:0]  dj;
        logic [W-1:0]  dk;
        logic          ok;
        logic [EW-1:0] ec;
        q  = q0;
        ok = 1'b0;
        for (int a = 0; a <= MR && !ok; a++) begin
`ifdef JK_TOGGLE_PREF_EN
            dj = q ^ t;
            dk = q ^ t;
`else
            dj = ~q & t;
            dk = q & ~t;
`endif
            exq.push_back(mk(1'b0, 1'b1, 1'b0, cur.de, '0, '0, cur.ec));
            exq.push_back(mk(1'b0, 1'b1, 1'b0, cur.de, dj, dk, cur.ec));
            exq.push_back(mk(1'b0, 1'b1, 1'b0, cur.de, '0, '0, cur.ec));
            q  = t & ~stuck;
            ok = (q == t);
        end
        ec = cur.ec;
        if (!ok && ec != '1) ec = ec + EW'(1);
        exq.push_back(mk(1'b1, 1'b0, 1'b1, !ok, '0, '0, ec));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exq.delete();
            cur = mk(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        end else begin
            if (cur.r && tgt_valid) plan(tgt_data, q_in);
            if (exq.size() > 0) cur = exq.pop_front();
            else cur = mk(1'b1, 1'b0, 1'b0, cur.de, '0, '0, cur.ec);
        end
    end

    always @(negedge clk) begin
        exp_t act;
        if (rst_n) begin
            act = mk(tgt_ready, busy, done_valid, done_err, j_out, k_out, err_cnt);
            vectors++;
            if (act !== cur) begin
                miscompares++;
                $display("FAIL cycle t=%0t got r%0b b%0b dv%0b de%0b j%h k%h ec%0d want r%0b b%0b dv%0b de%0b j%h k%h ec%0d",
                         $time, act.r, act.b, act.dv, act.de, act.j, act.k, act.ec,
                         cur.r, cur.b, cur.dv, cur.de, cur.j, cur.k, cur.ec);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns latency, first-APPLY drive and done_err.
    task automatic run_req(input logic [W-1:0] t, output int lat,
                           output logic [W-1:0] ja, output logic [W-1:0] ka,
                           output logic de);
        lat = -1;
        ja  = '0;
        ka  = '0;
        de  = 1'b0;
        for (int c = 0; c < 20 && !tgt_ready; c++) @(negedge clk);
        tgt_valid = 1'b1;
        tgt_data  = t;
        @(negedge clk);
        tgt_valid = 1'b0;
        tgt_data  = ~t;
        for (int c = 0; c < 20; c++) begin
            if (c == 1) begin
                ja = j_out;
                ka = k_out;
            end
            if (done_valid) begin
                lat = c;
                de  = done_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        tgt_valid = 1'b0;
        for (int c = 0; c < 20 && !(tgt_ready && exq.size() == 0); c++)
            @(negedge clk);
    endtask

    initial begin
        int           lat;
        int           dvn;
        logic [W-1:0] ja;
        logic [W-1:0] ka;
        logic         de;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(tgt_ready), 32'd1);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_j",     32'(j_out),     32'd0);
        chk("rst_k",     32'(k_out),     32'd0);
        chk("rst_dv",    32'(done_valid), 32'd0);
        chk("rst_de",    32'(done_err),  32'd0);
        chk("rst_ec",    32'(err_cnt),   32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        run_req(4'b1010, lat, ja, ka, de);
        chk("basic_lat", 32'(lat), 32'd3);
`ifdef JK_TOGGLE_PREF_EN
        chk("basic_j", 32'(ja), 32'b1010);
        chk("basic_k", 32'(ka), 32'b1010);
`else
        chk("basic_j", 32'(ja), 32'b1010);
        chk("basic_k", 32'(ka), 32'b0000);
`endif
        chk("basic_de", 32'(de), 32'd0);
        chk("basic_q",  32'(q_in), 32'b1010);

        run_req(4'b0110, lat, ja, ka, de);
        chk("mixed_lat", 32'(lat), 32'd3);
`ifdef JK_TOGGLE_PREF_EN
        chk("mixed_j", 32'(ja), 32'b1100);
        chk("mixed_k", 32'(ka), 32'b1100);
`else
        chk("mixed_j", 32'(ja), 32'b0100);
        chk("mixed_k", 32'(ka), 32'b1000);
`endif
        chk("mixed_q", 32'(q_in), 32'b0110);

        run_req(4'b0110, lat, ja, ka, de);
        chk("same_lat", 32'(lat), 32'd3);
        chk("same_j",   32'(ja),  32'd0);
        chk("same_k",   32'(ka),  32'd0);
        chk("same_de",  32'(de),  32'd0);

        stuck = 4'b0001;
        run_req(4'b0001, lat, ja, ka, de);
        chk("retry_lat", 32'(lat), 32'd6);
`ifdef JK_TOGGLE_PREF_EN
        chk("retry_j", 32'(ja), 32'b0111);
        chk("retry_k", 32'(ka), 32'b0111);
`else
        chk("retry_j", 32'(ja), 32'b0001);
        chk("retry_k", 32'(ka), 32'b0110);
`endif
        chk("retry_de", 32'(de),      32'd1);
        chk("retry_ec", 32'(err_cnt), 32'd1);

        // reset while the bank is being driven
        stuck     = '0;
        tgt_valid = 1'b1;
        tgt_data  = 4'b1111;
        @(negedge clk);
        tgt_valid = 1'b0;
        @(negedge clk);
        chk("mid_apply_j", 32'(j_out), 32'b1111);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_j",     32'(j_out),     32'd0);
        chk("mid_rst_k",     32'(k_out),     32'd0);
        chk("mid_rst_busy",  32'(busy),      32'd0);
        chk("mid_rst_ready", 32'(tgt_ready), 32'd1);
        chk("mid_rst_ec",    32'(err_cnt),   32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        dvn = 0;
        repeat (6) begin
            @(negedge clk);
            if (done_valid) dvn++;
        end
        chk("mid_rst_nodone", 32'(dvn),  32'd0);
        chk("mid_rst_q",      32'(q_in), 32'd0);

        stuck = 4'b0001;
        for (int i = 0; i < 9; i++) begin
            run_req(4'b0001, lat, ja, ka, de);
            if (i == 2) chk("sat_ec3", 32'(err_cnt), 32'd3);
        end
        chk("sat_ec", 32'(err_cnt), 32'd7);
        chk("sat_de", 32'(de),      32'd1);

        for (int blk = 0; blk < 8; blk++) begin
            wait_idle();
            stuck = (blk % 3 == 2) ? (W'($urandom) & W'($urandom)) : '0;
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                tgt_valid = ($urandom_range(0, 3) != 0);
                tgt_data  = W'($urandom);
            end
        end
        wait_idle();
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
